// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage and the 16-bit ALU: widths, opcodes,
// the latched ID/EX payload and the capture-time register read helper.
package id_ex_stage_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned RA  = 4;
  localparam int unsigned IW  = 8;
  localparam int unsigned OPW = 3;
  localparam int unsigned SCW = 16;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_NOR = 3'b010;
  localparam logic [OPW-1:0] OP_ADD = 3'b011;
  localparam logic [OPW-1:0] OP_SUB = 3'b100;
  localparam logic [OPW-1:0] OP_SLT = 3'b101;

  typedef struct packed {
    logic [RA-1:0]  rs_addr;
    logic [RA-1:0]  rt_addr;
    logic [RA-1:0]  rd_addr;
    logic [OPW-1:0] alu_op;
    logic           wr_en;
    logic           use_imm;
    logic [DW-1:0]  imm_ext;
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
  } idex_payload_t;

  function automatic logic [DW-1:0] extend_imm(input logic [IW-1:0] imm,
                                               input logic          zext);
    logic [DW-IW-1:0] hi;
    hi = zext ? '0 : {(DW-IW){imm[IW-1]}};
    return {hi, imm};
  endfunction

  // Regfile read with write-through of the same-cycle MEM/WB write; r0 reads 0.
  function automatic logic [DW-1:0] read_wt(input logic [RA-1:0] addr,
                                            input logic [DW-1:0] rf_data,
                                            input logic          wb_wr_en,
                                            input logic [RA-1:0] wb_rd,
                                            input logic [DW-1:0] wb_data);
    logic [DW-1:0] res;
    if (addr == '0) begin
      res = '0;
    end else if (wb_wr_en && (wb_rd == addr)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Three-source priority bypass mux for one ALU operand: EX/MEM over MEM/WB
// over the latched register value, with r0 never forwarded and always zero.
module operand_fwd
  import id_ex_stage_pkg::*;
(
  input  logic [RA-1:0] addr_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          exm_wr_en_i,
  input  logic [RA-1:0] exm_rd_i,
  input  logic [DW-1:0] exm_data_i,
  input  logic          wb_wr_en_i,
  input  logic [RA-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] fwd_data_c_o
);

  logic addr_nz_c;
  logic exm_hit_c;
  logic wb_hit_c;

  assign addr_nz_c = (addr_i != '0);
  assign exm_hit_c = exm_wr_en_i && (exm_rd_i == addr_i) && addr_nz_c;
  assign wb_hit_c  = wb_wr_en_i && (wb_rd_i == addr_i) && addr_nz_c;

  always_comb begin
    fwd_data_c_o = '0;
    if (!addr_nz_c) begin
      fwd_data_c_o = '0;
    end else if (exm_hit_c) begin
      fwd_data_c_o = exm_data_i;
    end else if (wb_hit_c) begin
      fwd_data_c_o = wb_data_i;
    end else begin
      fwd_data_c_o = reg_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: valid/ready handshake, flush,
// combinational operand forwarding from the held state, and a stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [RA-1:0]  rs_addr,
  input  logic [RA-1:0]  rt_addr,
  input  logic [RA-1:0]  rd_addr,
  input  logic [DW-1:0]  rs_data,
  input  logic [DW-1:0]  rt_data,
  input  logic [IW-1:0]  imm,
  input  logic           use_imm,
  input  logic           imm_zext,
  input  logic [OPW-1:0] alu_op_in,
  input  logic           wr_en_in,
  input  logic           flush,
  input  logic           ex_ready,
  input  logic           exm_wr_en,
  input  logic [RA-1:0]  exm_rd,
  input  logic [DW-1:0]  exm_data,
  input  logic           wb_wr_en,
  input  logic [RA-1:0]  wb_rd,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [RA-1:0]  rd_out,
  output logic           wr_en_out,
  output logic [SCW-1:0] stall_cycles
);

  idex_payload_t  pay_q, pay_d;
  logic           valid_q, valid_d;
  logic [SCW-1:0] stall_q, stall_d;

  logic           capture_c;
  logic           stall_c;
  logic [DW-1:0]  fwd_a_c;
  logic [DW-1:0]  fwd_b_c;

  assign in_ready  = !valid_q || ex_ready;
  assign capture_c = in_valid && in_ready && !flush;
  assign stall_c   = valid_q && !ex_ready && !flush;

  // Next-state for payload, valid flag and saturating stall counter.
  always_comb begin
    pay_d   = pay_q;
    valid_d = valid_q;
    stall_d = stall_q;

    if (capture_c) begin
      pay_d.rs_addr = rs_addr;
      pay_d.rt_addr = rt_addr;
      pay_d.rd_addr = rd_addr;
      pay_d.alu_op  = alu_op_in;
      pay_d.wr_en   = wr_en_in;
      pay_d.use_imm = use_imm;
      pay_d.imm_ext = extend_imm(imm, imm_zext);
      pay_d.rs_data = read_wt(rs_addr, rs_data, wb_wr_en, wb_rd, wb_data);
      pay_d.rt_data = read_wt(rt_addr, rt_data, wb_wr_en, wb_rd, wb_data);
    end

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_c) begin
      valid_d = 1'b1;
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end

    if (stall_c && (stall_q != '1)) begin
      stall_d = stall_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      pay_q   <= pay_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  operand_fwd u_fwd_a (
    .addr_i       (pay_q.rs_addr),
    .reg_data_i   (pay_q.rs_data),
    .exm_wr_en_i  (exm_wr_en),
    .exm_rd_i     (exm_rd),
    .exm_data_i   (exm_data),
    .wb_wr_en_i   (wb_wr_en),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data),
    .fwd_data_c_o (fwd_a_c)
  );

  operand_fwd u_fwd_b (
    .addr_i       (pay_q.rt_addr),
    .reg_data_i   (pay_q.rt_data),
    .exm_wr_en_i  (exm_wr_en),
    .exm_rd_i     (exm_rd),
    .exm_data_i   (exm_data),
    .wb_wr_en_i   (wb_wr_en),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data),
    .fwd_data_c_o (fwd_b_c)
  );

  // Everything presented to the ALU is zeroed while the stage is empty.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    rd_out    = '0;
    wr_en_out = 1'b0;
    if (valid_q) begin
      alu_a     = fwd_a_c;
      alu_b     = pay_q.use_imm ? pay_q.imm_ext : fwd_b_c;
      alu_op    = pay_q.alu_op;
      rd_out    = pay_q.rd_addr;
      wr_en_out = pay_q.wr_en;
    end
  end

  assign out_valid    = valid_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for capture/forwarding plus
// hand sequences for stall, flush, reset-mid-stall and counter saturation.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [RA-1:0]  rs_addr, rt_addr, rd_addr;
  logic [DW-1:0]  rs_data, rt_data;
  logic [IW-1:0]  imm;
  logic           use_imm, imm_zext;
  logic [OPW-1:0] alu_op_in;
  logic           wr_en_in;
  logic           flush;
  logic           ex_ready;
  logic           exm_wr_en;
  logic [RA-1:0]  exm_rd;
  logic [DW-1:0]  exm_data;
  logic           wb_wr_en;
  logic [RA-1:0]  wb_rd;
  logic [DW-1:0]  wb_data;
  logic           out_valid;
  logic [DW-1:0]  alu_a, alu_b;
  logic [OPW-1:0] alu_op;
  logic [RA-1:0]  rd_out;
  logic           wr_en_out;
  logic [15:0]    stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .use_imm(use_imm),
    .imm_zext(imm_zext), .alu_op_in(alu_op_in), .wr_en_in(wr_en_in),
    .flush(flush), .ex_ready(ex_ready),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .rd_out(rd_out), .wr_en_out(wr_en_out), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [3:0]  rs, rt, rd;
    logic [15:0] rs_d, rt_d;
    logic [7:0]  imm;
    logic        ui, zx;
    logic [2:0]  op;
    logic        wr;
    logic        cwb_en;
    logic [3:0]  cwb_rd;
    logic [15:0] cwb_d;
    logic        x_en;
    logic [3:0]  x_rd;
    logic [15:0] x_d;
    logic        w_en;
    logic [3:0]  w_rd;
    logic [15:0] w_d;
    logic [15:0] ea, eb;
    logic [2:0]  eop;
    logic [3:0]  erd;
    logic        ewr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                             input logic [15:0] rsd, input logic [15:0] rtd, input logic [2:0] op);
    in_valid = 1'b1; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; imm = '0; use_imm = 1'b0; imm_zext = 1'b0;
    alu_op_in = op; wr_en_in = 1'b1;
  endtask

  task automatic clear_bypass();
    exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    rs_addr = '0; rt_addr = '0; rd_addr = '0; rs_data = '0; rt_data = '0;
    imm = '0; use_imm = 1'b0; imm_zext = 1'b0; alu_op_in = '0; wr_en_in = 1'b0;
    clear_bypass();

    // rs  rt  rd  rs_d     rt_d     imm    ui zx op wr | cap wb | exm | wb | exp a, b, op, rd, wr
    vecs[0] = '{4'd1, 4'd2, 4'd4, 16'h0005, 16'h0003, 8'h00, 1'b0, 1'b0, 3'd3, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000,
                16'h0005, 16'h0003, 3'd3, 4'd4, 1'b1};
    vecs[1] = '{4'd1, 4'd2, 4'd5, 16'h0010, 16'h0003, 8'hF0, 1'b1, 1'b0, 3'd4, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000,
                16'h0010, 16'hFFF0, 3'd4, 4'd5, 1'b1};
    vecs[2] = '{4'd1, 4'd2, 4'd5, 16'h0010, 16'h0003, 8'hF0, 1'b1, 1'b1, 3'd4, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000,
                16'h0010, 16'h00F0, 3'd4, 4'd5, 1'b1};
    vecs[3] = '{4'd3, 4'd5, 4'd6, 16'h1111, 16'h0007, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h1234, 1'b1, 4'd3, 16'h5678,
                16'h1234, 16'h0007, 3'd0, 4'd6, 1'b1};
    vecs[4] = '{4'd3, 4'd5, 4'd6, 16'h1111, 16'h0007, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 16'h1234, 1'b1, 4'd3, 16'h5678,
                16'h5678, 16'h0007, 3'd0, 4'd6, 1'b1};
    vecs[5] = '{4'd0, 4'd5, 4'd6, 16'h9999, 16'h0007, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 16'h5678,
                16'h0000, 16'h0007, 3'd0, 4'd6, 1'b1};
    vecs[6] = '{4'd2, 4'd7, 4'd9, 16'h1111, 16'h0022, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1,
                1'b1, 4'd2, 16'hABCD, 1'b1, 4'd7, 16'h00EE, 1'b0, 4'd0, 16'h0000,
                16'hABCD, 16'h00EE, 3'd1, 4'd9, 1'b1};
    vecs[7] = '{4'd1, 4'd6, 4'd0, 16'h0005, 16'h0000, 8'h00, 1'b0, 1'b0, 3'd5, 1'b0,
                1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'h0F0F,
                16'h0005, 16'h0F0F, 3'd5, 4'd0, 1'b0};
    vecs[8] = '{4'd1, 4'd8, 4'd3, 16'h0005, 16'h0000, 8'h7F, 1'b1, 1'b0, 3'd6, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b1, 4'd8, 16'hFFFF, 1'b0, 4'd0, 16'h0000,
                16'h0005, 16'h007F, 3'd6, 4'd3, 1'b1};
    vecs[9] = '{4'd4, 4'd2, 4'd15, 16'h00A0, 16'h0000, 8'h80, 1'b1, 1'b0, 3'd7, 1'b1,
                1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'h0BBB, 1'b1, 4'd4, 16'h0CCC,
                16'h0BBB, 16'hFF80, 3'd7, 4'd15, 1'b1};

    step(); step();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rd_wr", 32'({rd_out, wr_en_out}), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);

    // Back-to-back captures with ex_ready held high.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rs_addr = vecs[i].rs; rt_addr = vecs[i].rt; rd_addr = vecs[i].rd;
      rs_data = vecs[i].rs_d; rt_data = vecs[i].rt_d; imm = vecs[i].imm;
      use_imm = vecs[i].ui; imm_zext = vecs[i].zx; alu_op_in = vecs[i].op;
      wr_en_in = vecs[i].wr;
      exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0;
      wb_wr_en = vecs[i].cwb_en; wb_rd = vecs[i].cwb_rd; wb_data = vecs[i].cwb_d;
      step();
      in_valid = 1'b0;
      exm_wr_en = vecs[i].x_en; exm_rd = vecs[i].x_rd; exm_data = vecs[i].x_d;
      wb_wr_en = vecs[i].w_en; wb_rd = vecs[i].w_rd; wb_data = vecs[i].w_d;
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].ea));
      check($sformatf("v%0d_alu_b", i), 32'(alu_b), 32'(vecs[i].eb));
      check($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].eop));
      check($sformatf("v%0d_rd_out", i), 32'(rd_out), 32'(vecs[i].erd));
      check($sformatf("v%0d_wr_en_out", i), 32'(wr_en_out), 32'(vecs[i].ewr));
    end
    clear_bypass();
    step();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_alu_a", 32'(alu_a), 32'd0);
    check("drain_wr_en_out", 32'(wr_en_out), 32'd0);

    // Stall for 4 cycles; a new request during the stall must not disturb the held op.
    drive_instr(4'd1, 4'd2, 4'd4, 16'h0005, 16'h0003, OP_ADD);
    step();
    ex_ready = 1'b0;
    drive_instr(4'd7, 4'd8, 4'd9, 16'hDEAD, 16'hBEEF, OP_NOR);
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("stall%0d_alu_a", c), 32'(alu_a), 32'h0005);
      check($sformatf("stall%0d_alu_b", c), 32'(alu_b), 32'h0003);
      check($sformatf("stall%0d_alu_op", c), 32'(alu_op), 32'(OP_ADD));
    end
    check("stall_count4", 32'(stall_cycles), 32'd4);
    check("stall_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_stall_hold", 32'(stall_cycles), 32'd4);

    // Capture attempt coinciding with flush is dropped.
    ex_ready = 1'b1;
    drive_instr(4'd1, 4'd2, 4'd4, 16'h0005, 16'h0003, OP_ADD);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_cap_out_valid", 32'(out_valid), 32'd0);
    check("flush_cap_alu_a", 32'(alu_a), 32'd0);

    // Reset while stalled discards the held instruction and the counter.
    drive_instr(4'd1, 4'd2, 4'd4, 16'h0005, 16'h0003, OP_ADD);
    step();
    in_valid = 1'b0; ex_ready = 1'b0;
    step();
    check("pre_rst_stall", 32'(stall_cycles), 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stall", 32'(stall_cycles), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Long stall to drive the counter into saturation.
    ex_ready = 1'b1;
    drive_instr(4'd1, 4'd2, 4'd4, 16'h0005, 16'h0003, OP_ADD);
    step();
    in_valid = 1'b0; ex_ready = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(stall_cycles), 32'h0000_FFFE);
    step();
    check("sat_ffff", 32'(stall_cycles), 32'h0000_FFFF);
    step(); step();
    check("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);
    check("sat_still_valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the 16-bit ALU. It captures decoded register operands, immediate, ALU opcode and destination register from decode, then presents the ALU with final A/B operands after EX/MEM and MEM/WB forwarding. A valid/ready handshake handles stalls, and a flush input squashes the stage on taken branches. It also keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- DW, 16, datapath width (ALU operand width)
- RA, 4, register address width (16 registers, r0 hardwired zero)
- IW, 8, immediate field width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs_addr, rt_addr, rd_addr  in  RA  source/destination register numbers
- rs_data, rt_data  in  DW  register-file read data
- imm  in  IW  raw immediate
- use_imm  in  1  B operand = extended immediate instead of rt
- imm_zext  in  1  1 = zero-extend imm, 0 = sign-extend
- alu_op_in  in  3  ALU opcode
- wr_en_in  in  1  instruction writes rd
- flush  in  1  squash stage contents
- ex_ready  in  1  ALU/EX stage accepts this cycle
- exm_wr_en, exm_rd, exm_data  in  1/RA/DW  EX/MEM result bypass
- wb_wr_en, wb_rd, wb_data  in  1/RA/DW  MEM/WB result bypass (same-cycle regfile write)
- out_valid  out  1  stage holds a live instruction
- alu_a, alu_b  out  DW  final ALU operands
- alu_op  out  3  ALU opcode
- rd_out  out  RA  destination register
- wr_en_out  out  1  write-enable, gated by out_valid
- stall_cycles  out  16  saturating count of stalled cycles

## Operation
- in_ready = !out_valid | ex_ready (combinational). Capture occurs when in_valid & in_ready & !flush.
- Capture latches rs_addr, rt_addr, rd_addr, alu_op_in, wr_en_in, use_imm, and the extended immediate (IW to DW per imm_zext).
- Capture also latches rs_q/rt_q with write-through: if wb_wr_en & wb_rd == addr & addr != 0, latch wb_data; else latch the regfile data.
- out_valid next-state:
  - flush → 0
  - capture → 1
  - out_valid & ex_ready → 0
  - otherwise hold
- While holding, all latched fields are stable.
- Output forwarding is combinational from the latched state, evaluated every cycle, so it stays correct during stalls.
- A-side forwarding priority:
  - exm_wr_en & exm_rd == rs_q_addr & rs_q_addr != 0 → exm_data
  - else wb_wr_en & wb_rd == rs_q_addr & rs_q_addr != 0 → wb_data
  - else rs_q
- B side: if use_imm, the extended immediate. Otherwise the same forwarding on rt.
- r0 is never forwarded and always reads 0.
- When out_valid = 0: alu_a, alu_b, alu_op, rd_out and wr_en_out are all driven to 0.
- stall_cycles increments on each cycle with out_valid & !ex_ready & !flush, and saturates at 0xFFFF.
- Opcodes: AND 000, OR 001, NOR 010, ADD 011, SUB 100, SLT 101. Codes 110/111 pass through unchanged (the ALU yields 0).

## Timing
- Latency is 1 cycle: an instruction captured at edge N is presented with out_valid = 1 after edge N.
- Back-to-back throughput is 1 instruction per cycle while ex_ready = 1.
- Reset (synchronous) sets out_valid = 0, all latched fields = 0, and stall_cycles = 0. Hence alu_a = alu_b = 0, alu_op = 0, rd_out = 0, wr_en_out = 0, and in_ready = 1.
- Reset mid-stall discards the held instruction.
- flush & capture in the same cycle: flush wins and the incoming instruction is dropped. Decode must reissue it.
- flush while stalled: the instruction is dropped, and stall_cycles does not count that cycle.
- Simultaneous exm and wb hits on the same register: exm wins.

## Structure
- Shared package: DW, RA, IW, and the ALU opcode constants (OP_AND … OP_SLT). The ALU uses the same package.
- Sub-module `operand_fwd`: a 3-source priority bypass mux (exm/wb/reg with r0 check), instantiated twice for A and B.

## Test plan
- Reset, then idle → out_valid = 0, in_ready = 1, alu_a = alu_b = 0, stall_cycles = 0.
- Capture ADD: rs = r1 (data 0x0005), rt = r2 (data 0x0003), no bypass hits → one cycle later alu_a = 0x0005, alu_b = 0x0003, alu_op = 011, out_valid = 1.
- use_imm = 1, imm = 0xF0: imm_zext = 0 → alu_b = 0xFFF0; imm_zext = 1 → alu_b = 0x00F0.
- Held rs = r3 with exm_rd = r3, exm_data = 0x1234 and wb_rd = r3, wb_data = 0x5678 → alu_a = 0x1234. Deassert exm_wr_en → alu_a = 0x5678. rs = r0 with both hits → alu_a = 0.
- ex_ready = 0 for 4 cycles with a live instruction → outputs stable, in_ready = 0, stall_cycles = 4. Then flush → out_valid = 0 next cycle and stall_cycles stays 4.
- in_valid & flush in the same cycle → no capture (out_valid stays 0). Preload stall_cycles near 0xFFFF and stall → it saturates at 0xFFFF.
